bcd_updown_counter: RTL
=======================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2, SHALL set the number of BCD decades, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 100_000_000, SHALL set the clk cycles per count step, legal range 1..2^27.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port en, input, 1 bit, SHALL enable the prescaler and the counting.
REQ-006 Port up, input, 1 bit, SHALL select the count direction: 1 = increment, 0 = decrement.
REQ-007 Port load, input, 1 bit, SHALL be a synchronous parallel-load strobe.
REQ-008 Port load_val, input, 4*DIGITS bits, SHALL carry the BCD load value, with digit 0 in bits [3:0].
REQ-009 Port count, output, 4*DIGITS bits, SHALL carry the registered BCD count, with digit 0 in bits [3:0].
REQ-010 Port tick, output, 1 bit, SHALL be a registered one-cycle pulse marking each count step.
REQ-011 Port wrap, output, 1 bit, SHALL be a registered one-cycle pulse marking a roll-over or a saturation hit.

Function
REQ-012 The prescaler SHALL be ceil(log2(TICK_DIV)) bits wide (minimum 1) and count 0..TICK_DIV-1 while en=1.
- It wraps to 0 after TICK_DIV-1.
- It holds its value while en=0.
REQ-013 A step event SHALL occur in any cycle where en=1, load=0 and the prescaler equals TICK_DIV-1.
- With TICK_DIV=1, every enabled cycle is a step.
REQ-014 On a step, count SHALL change by exactly one in the direction given by up as sampled in that same cycle.
REQ-015 Decade arithmetic, increment: a digit at 9 SHALL go to 0 and carry into the next digit; each digit stays within 0..9.
REQ-016 Decade arithmetic, decrement: a digit at 0 SHALL go to 9 and borrow from the next digit; each digit stays within 0..9.
REQ-017 Increment from all-9s SHALL give all-0s; decrement from all-0s SHALL give all-9s.
- wrap pulses in the cycle the new count is visible (default build only; see REQ-027).
REQ-018 tick SHALL be high in the cycle after each step event, aligned with the updated count.
REQ-019 load=1 SHALL have priority over stepping.
- Next cycle: count = load_val and the prescaler is 0.
- tick=0 and wrap=0 that cycle.
- load acts regardless of en.
REQ-020 Any load_val digit greater than 9 SHALL be loaded as 9; the other digits load unchanged.
REQ-021 With en=0 and load=0, count, the prescaler and the pulses SHALL hold.
- tick and wrap stay 0.
REQ-022 A change of up between steps SHALL take effect only at the next step and SHALL NOT reset the prescaler.

Reset
REQ-023 While reset=0, the prescaler, count, tick and wrap SHALL all be 0, asynchronously.
REQ-024 After reset deasserts, the first step SHALL occur on the TICK_DIV-th enabled cycle.
REQ-025 Reset asserted mid-prescale or mid-load SHALL abort the operation; nothing is retained.

Configuration
REQ-026 The macro BCD_COUNTER_SATURATE_EN SHALL select between wrap-around and saturating operation.
REQ-027 With BCD_COUNTER_SATURATE_EN undefined, the counter wraps per REQ-017.
REQ-028 With BCD_COUNTER_SATURATE_EN defined, the counter saturates instead of wrapping.
- Increment at all-9s holds all-9s; decrement at all-0s holds all-0s.
- tick still pulses.
- wrap pulses on each such blocked step.

Verification (DIGITS=2, TICK_DIV=4 unless stated)
REQ-029 Reset, then en=1, up=1: count goes 00 -> 01 on the 4th enabled cycle, with tick high that cycle only; after 40 steps count = 40.
REQ-030 load_val=8'h99, load pulse, then one up step: count = 00 with wrap=1 (default build); with BCD_COUNTER_SATURATE_EN, count = 99 with wrap=1.
REQ-031 load_val=8'h10, up=0, one step: count = 09; load_val=8'h00, one down step: count = 99 with wrap=1 (default build).
REQ-032 load_val=8'hA5: count = 95; load asserted in the same cycle as a step: count = load_val, tick=0, prescaler restarts at 0.
REQ-033 en dropped for 10 cycles with the prescaler at 2: count and prescaler hold; the step occurs 2 enabled cycles after en returns.
REQ-034 reset pulsed low asynchronously mid-count: count = 00 immediately; with DIGITS=1 and TICK_DIV=1, count steps 0..9 -> 0 on consecutive cycles.

Source files
------------

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Purpose  : Multi-decade BCD up/down counter with prescaler, parallel load
//            (out-of-range digits clamped to 9), tick and wrap pulses.
// Options  : define BCD_COUNTER_SATURATE_EN to saturate at 0/all-9s instead
//            of rolling over.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap
);

  localparam int              CW     = 4 * DIGITS;
  localparam int              PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] prescaler_q, prescaler_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;

  logic [CW-1:0]   load_clamped;
  logic [CW-1:0]   stepped;
  // Carry (up) or borrow (down) out of the most significant decade: the
  // count sits at all-9s (up) or all-0s (down), i.e. the step is a roll-over.
  logic            edge_hit;

  // Digits above 9 are not valid BCD; clamp each one independently to 9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
    assign load_clamped[4*g +: 4] = (load_val[4*g +: 4] > 4'd9) ? 4'd9 : load_val[4*g +: 4];
  end

  // Ripple one step through the decades, carrying/borrowing while a digit wraps.
  always_comb begin
    stepped  = count_q;
    edge_hit = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (edge_hit) begin
        if (up) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            edge_hit          = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            edge_hit          = 1'b0;
          end
        end
      end
    end
  end

  // Next state: load beats stepping; en=0 freezes prescaler and count.
  always_comb begin
    prescaler_d = prescaler_q;
    count_d     = count_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    if (load) begin
      prescaler_d = '0;
      count_d     = load_clamped;
    end else if (en) begin
      if (prescaler_q == PS_MAX) begin
        prescaler_d = '0;
        tick_d      = 1'b1;
        wrap_d      = edge_hit;
`ifdef BCD_COUNTER_SATURATE_EN
        // A step that would roll over is blocked; the count stays at the limit.
        if (!edge_hit) begin
          count_d = stepped;
        end
`else
        count_d = stepped;
`endif
      end else begin
        prescaler_d = prescaler_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q <= '0;
      count_q     <= '0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      count_q     <= count_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire
